// File: rtl/pulse_height_extractor.sv
// Pulse height extractor: threshold/hysteresis pulse detection on a baseline-referenced
// ADC stream, peak tracking, pile-up rejection and a one-entry histogram bin output.
module pulse_height_extractor #(
  parameter int SAMPLE_WIDTH  = 14,
  parameter int BIN_BITS      = 10,
  parameter int MAX_PULSE_LEN = 64,
  parameter int DEAD_TIME     = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic [SAMPLE_WIDTH-1:0] baseline,
  input  logic [SAMPLE_WIDTH-1:0] threshold,
  input  logic [SAMPLE_WIDTH-1:0] hysteresis,
  output logic                    bin_valid,
  output logic [BIN_BITS-1:0]     bin_index,
  input  logic                    bin_ready,
  output logic                    busy,
  output logic [31:0]             pulse_count,
  output logic [15:0]             reject_count,
  output logic [15:0]             drop_count
);

  localparam int LEN_W  = $clog2(MAX_PULSE_LEN + 2);
  localparam int DEAD_W = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PULSE_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_PULSE_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOW,
    S_ARMED,
    S_IN_PULSE,
    S_DEAD
  } state_t;

  state_t                  r_state;
  logic [SAMPLE_WIDTH-1:0] r_peak;
  logic [LEN_W-1:0]        r_len;
  logic [DEAD_W-1:0]       r_dead;
  logic                    r_bin_valid;
  logic [BIN_BITS-1:0]     r_bin_index;
  logic [31:0]             r_pulse_count;
  logic [15:0]             r_reject_count;
  logic [15:0]             r_drop_count;

  logic [SAMPLE_WIDTH-1:0] w_amp;
  logic [SAMPLE_WIDTH-1:0] w_lo;
  logic                    w_beat;
  logic                    w_trig;
  logic                    w_arm_ok;
  logic                    w_pulse_end;
  logic                    w_accept;
  logic                    w_reject;
  logic                    w_handshake;
  logic [BIN_BITS-1:0]     w_result;

  assign w_amp    = (sample >= baseline) ? sample - baseline : '0;
  assign w_lo     = (threshold >= hysteresis) ? threshold - hysteresis : '0;
  assign w_beat   = enable && sample_valid;
  assign w_trig   = (w_amp >= threshold);
  // With a zero threshold nothing is ever below it, yet every beat must still arm.
  assign w_arm_ok = (w_amp < threshold) || (threshold == '0);

  assign w_pulse_end = w_beat && (r_state == S_IN_PULSE) && (w_amp < w_lo);
  assign w_accept    = w_pulse_end && (r_len <= LEN_MAX);
  assign w_reject    = w_pulse_end && (r_len > LEN_MAX);
  assign w_handshake = r_bin_valid && bin_ready;
  assign w_result    = r_peak[SAMPLE_WIDTH-1 -: BIN_BITS];

  // NOTE: all state uses non-blocking assignments under the async reset so every
  // register samples the same pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_peak  <= '0;
      r_len   <= '0;
      r_dead  <= '0;
    end else if (!enable) begin
      r_state <= S_IDLE;
      r_peak  <= '0;
      r_len   <= '0;
      r_dead  <= '0;
    end else if (sample_valid) begin
      case (r_state)
        S_IDLE: r_state <= S_WAIT_LOW;
        S_WAIT_LOW: if (w_arm_ok) r_state <= S_ARMED;
        S_ARMED: begin
          if (w_trig) begin
            r_state <= S_IN_PULSE;
            r_peak  <= w_amp;
            r_len   <= LEN_W'(1);
          end
        end
        S_IN_PULSE: begin
          if (w_amp < w_lo) begin
            if (DEAD_TIME == 0) begin
              r_state <= w_arm_ok ? S_ARMED : S_WAIT_LOW;
            end else begin
              r_state <= S_DEAD;
              r_dead  <= DEAD_W'(DEAD_TIME);
            end
          end else begin
            if (w_amp > r_peak) r_peak <= w_amp;
            if (r_len != LEN_SAT) r_len <= r_len + LEN_W'(1);
          end
        end
        S_DEAD: begin
          if (r_dead <= DEAD_W'(1)) begin
            r_dead  <= '0;
            r_state <= w_arm_ok ? S_ARMED : S_WAIT_LOW;
          end else begin
            r_dead <= r_dead - DEAD_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Single-entry output register; a result arriving while it is held is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bin_valid    <= 1'b0;
      r_bin_index    <= '0;
      r_pulse_count  <= '0;
      r_reject_count <= '0;
      r_drop_count   <= '0;
    end else begin
      if (w_accept) begin
        if (r_pulse_count != '1) r_pulse_count <= r_pulse_count + 32'd1;
        if (!r_bin_valid || w_handshake) begin
          r_bin_valid <= 1'b1;
          r_bin_index <= w_result;
        end else if (r_drop_count != '1) begin
          r_drop_count <= r_drop_count + 16'd1;
        end
      end else if (w_handshake) begin
        r_bin_valid <= 1'b0;
      end
      if (w_reject && (r_reject_count != '1)) r_reject_count <= r_reject_count + 16'd1;
    end
  end

  assign bin_valid    = r_bin_valid;
  assign bin_index    = r_bin_index;
  assign busy         = (r_state == S_IN_PULSE) || (r_state == S_DEAD);
  assign pulse_count  = r_pulse_count;
  assign reject_count = r_reject_count;
  assign drop_count   = r_drop_count;

endmodule

// File: tb/tb_pulse_height_extractor.sv
// Directed bench for pulse_height_extractor: baseline 100, threshold 200, hysteresis 20
// (end level 180), hand-computed bins and counter values for each scenario.
module tb_pulse_height_extractor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        sample_valid;
  logic [13:0] sample;
  logic [13:0] baseline;
  logic [13:0] threshold;
  logic [13:0] hysteresis;
  logic        bin_valid;
  logic [9:0]  bin_index;
  logic        bin_ready;
  logic        busy;
  logic [31:0] pulse_count;
  logic [15:0] reject_count;
  logic [15:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;
  int hs_count = 0;
  int hs_last = -1;

  pulse_height_extractor dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample       (sample),
    .baseline     (baseline),
    .threshold    (threshold),
    .hysteresis   (hysteresis),
    .bin_valid    (bin_valid),
    .bin_index    (bin_index),
    .bin_ready    (bin_ready),
    .busy         (busy),
    .pulse_count  (pulse_count),
    .reject_count (reject_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  // Handshake observer: records each accepted bin as the histogram would see it.
  always @(posedge clk) begin
    if (reset_n && bin_valid && bin_ready) begin
      hs_count++;
      hs_last = int'(bin_index);
    end
  end

  task automatic send(input int s);
    @(negedge clk);
    sample_valid = 1'b1;
    sample       = 14'(s);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic flush_dead();
    for (int i = 0; i < 8; i++) send(100);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample = '0;
    baseline = 14'd100; threshold = 14'd200; hysteresis = 14'd20; bin_ready = 1'b1;
    #12;
    n_cmp++; if (bin_valid !== 1'b0) begin n_err++; $display("FAIL reset_bin_valid got %0b want 0", bin_valid); end
    n_cmp++; if (bin_index !== 10'd0) begin n_err++; $display("FAIL reset_bin_index got %0d want 0", bin_index); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (pulse_count !== 32'd0 || reject_count !== 16'd0 || drop_count !== 16'd0) begin
      n_err++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", pulse_count, reject_count, drop_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_pulse();
    enable = 1'b1; bin_ready = 1'b1;
    send(100); send(100);
    send(250); send(600); send(900); send(500);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %0b want 1", busy); end
    n_cmp++; if (bin_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got %0b want 0", bin_valid); end
    send(150);
    n_cmp++; if (bin_valid !== 1'b1 || bin_index !== 10'd50) begin
      n_err++; $display("FAIL single_bin got valid=%0b idx=%0d want valid=1 idx=50", bin_valid, bin_index);
    end
    n_cmp++; if (pulse_count !== 32'd1) begin n_err++; $display("FAIL single_pulse_count got %0d want 1", pulse_count); end
    idle_cycle();
    n_cmp++; if (bin_valid !== 1'b0 || hs_count !== 1 || hs_last !== 50) begin
      n_err++; $display("FAIL single_handshake got valid=%0b hs=%0d last=%0d want 0/1/50", bin_valid, hs_count, hs_last);
    end
    for (int i = 0; i < 7; i++) send(100);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL dead_7th_beat_busy got %0b want 1", busy); end
    send(100);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dead_8th_beat_busy got %0b want 0", busy); end
  endtask

  task automatic test_pileup();
    for (int i = 0; i < 70; i++) send(900);
    send(100);
    n_cmp++; if (reject_count !== 16'd1) begin n_err++; $display("FAIL pileup_reject got %0d want 1", reject_count); end
    n_cmp++; if (bin_valid !== 1'b0 || pulse_count !== 32'd1) begin
      n_err++; $display("FAIL pileup_no_bin got valid=%0b pulses=%0d want 0/1", bin_valid, pulse_count);
    end
    flush_dead();
    // Exactly MAX_PULSE_LEN samples is still a valid pulse.
    for (int i = 0; i < 64; i++) send(900);
    send(100);
    n_cmp++; if (bin_valid !== 1'b1 || bin_index !== 10'd50 || pulse_count !== 32'd2 || reject_count !== 16'd1) begin
      n_err++; $display("FAIL len64_accept got valid=%0b idx=%0d pulses=%0d rej=%0d want 1/50/2/1",
                        bin_valid, bin_index, pulse_count, reject_count);
    end
    flush_dead();
    n_cmp++; if (hs_count !== 2) begin n_err++; $display("FAIL len64_handshake got %0d want 2", hs_count); end
  endtask

  task automatic test_back_to_back();
    bin_ready = 1'b0;
    send(600); send(900); send(500); send(150);
    flush_dead();
    n_cmp++; if (bin_valid !== 1'b1 || bin_index !== 10'd50) begin
      n_err++; $display("FAIL bp_hold got valid=%0b idx=%0d want 1/50", bin_valid, bin_index);
    end
    send(1700); send(100);
    n_cmp++; if (bin_index !== 10'd50 || drop_count !== 16'd1 || pulse_count !== 32'd4) begin
      n_err++; $display("FAIL bp_drop got idx=%0d drops=%0d pulses=%0d want 50/1/4", bin_index, drop_count, pulse_count);
    end
    bin_ready = 1'b1;
    idle_cycle();
    idle_cycle();
    n_cmp++; if (hs_count !== 3 || hs_last !== 50 || bin_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release got hs=%0d last=%0d valid=%0b want 3/50/0", hs_count, hs_last, bin_valid);
    end
    flush_dead();
  endtask

  task automatic test_dead_time();
    send(600); send(900); send(150);
    for (int i = 0; i < 4; i++) send(100);
    for (int i = 0; i < 6; i++) send(1000);
    n_cmp++; if (busy !== 1'b0 || pulse_count !== 32'd5 || hs_count !== 4) begin
      n_err++; $display("FAIL dead_ignore got busy=%0b pulses=%0d hs=%0d want 0/5/4", busy, pulse_count, hs_count);
    end
    send(100);
    send(1200); send(100);
    n_cmp++; if (bin_valid !== 1'b1 || bin_index !== 10'd68 || pulse_count !== 32'd6) begin
      n_err++; $display("FAIL dead_rearm got valid=%0b idx=%0d pulses=%0d want 1/68/6", bin_valid, bin_index, pulse_count);
    end
    flush_dead();
  endtask

  task automatic test_enable();
    send(600); send(900);
    @(negedge clk);
    enable = 1'b0; sample_valid = 1'b0;
    @(posedge clk); #1;
    send(500); send(150);
    n_cmp++; if (busy !== 1'b0 || bin_valid !== 1'b0 || pulse_count !== 32'd6 || reject_count !== 16'd1) begin
      n_err++; $display("FAIL disable_mid got busy=%0b valid=%0b pulses=%0d rej=%0d want 0/0/6/1",
                        busy, bin_valid, pulse_count, reject_count);
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) send(900);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL late_enable_no_trigger got busy=%0b want 0", busy); end
    send(100); send(900);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL late_enable_trigger got busy=%0b want 1", busy); end
    send(100);
    n_cmp++; if (bin_index !== 10'd50 || pulse_count !== 32'd7) begin
      n_err++; $display("FAIL late_enable_bin got idx=%0d pulses=%0d want 50/7", bin_index, pulse_count);
    end
    flush_dead();
  endtask

  task automatic test_reset_mid();
    bin_ready = 1'b0;
    send(600); send(900); send(150);
    flush_dead();
    send(900);
    n_cmp++; if (bin_valid !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL rst_setup got valid=%0b busy=%0b want 1/1", bin_valid, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (bin_valid !== 1'b0 || busy !== 1'b0 || bin_index !== 10'd0) begin
      n_err++; $display("FAIL rst_async_outputs got valid=%0b busy=%0b idx=%0d want 0/0/0", bin_valid, busy, bin_index);
    end
    n_cmp++; if (pulse_count !== 32'd0 || reject_count !== 16'd0 || drop_count !== 16'd0) begin
      n_err++; $display("FAIL rst_async_counters got %0d/%0d/%0d want 0/0/0", pulse_count, reject_count, drop_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_pileup();
    test_back_to_back();
    test_dead_time();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_height_extractor.md
Name: pulse_height_extractor

Overview:
- Upstream stage of the hardware-accelerated histogram in the radiation receiver.
- Consumes the baseline-referenced ADC sample stream from the radiation processor and detects pulses by threshold crossing with hysteresis.
- Tracks each pulse's peak amplitude, rejects pile-up (over-long) pulses, and emits one histogram bin index per accepted pulse over a valid/ready handshake.
- Keeps saturating accepted/rejected/dropped counters for readout.

Parameters:
- SAMPLE_WIDTH, 14: ADC sample width; also the width of amplitude, baseline and threshold.
- BIN_BITS, 10: bin index width; bin = peak >> (SAMPLE_WIDTH-BIN_BITS).
- MAX_PULSE_LEN, 64: maximum in-pulse sample count; longer pulses are rejected as pile-up.
- DEAD_TIME, 8: sample_valid beats ignored after each pulse end.

Ports:
- clk  in  1  system clock (100 MHz)
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run control; low forces IDLE
- sample_valid  in  1  sample qualifier
- sample  in  SAMPLE_WIDTH  raw ADC sample (unsigned)
- baseline  in  SAMPLE_WIDTH  baseline; quasi-static
- threshold  in  SAMPLE_WIDTH  trigger level on amplitude
- hysteresis  in  SAMPLE_WIDTH  pulse ends when amp < threshold-hysteresis
- bin_valid  out  1  bin_index valid
- bin_index  out  BIN_BITS  histogram bin of accepted pulse
- bin_ready  in  1  histogram accepts bin
- busy  out  1  state is IN_PULSE or DEAD
- pulse_count  out  32  accepted pulses, saturating
- reject_count  out  16  pile-up rejects, saturating
- drop_count  out  16  bins lost to backpressure, saturating

Behaviour:
- Reset: state IDLE; bin_valid=0, bin_index=0, busy=0; all counters 0; peak, length and dead counters 0.
- Amplitude: amp = sample - baseline, saturated to 0 when sample < baseline.
- End level: lo = threshold - hysteresis, saturated to 0.
- FSM advances only on sample_valid beats, except the enable=0 transition, which applies every cycle.
- IDLE: when enable=1, go to WAIT_LOW.
- WAIT_LOW: arm only after seeing amp < threshold, so a pulse already in progress at enable is never partially captured; on such a beat go to ARMED.
- ARMED: on amp >= threshold go to IN_PULSE; set peak=amp, len=1.
- IN_PULSE:
  - amp >= lo: peak = max(peak, amp); len++, saturating at MAX_PULSE_LEN+1.
  - amp < lo: pulse ends; this sample is not counted. Go to DEAD and load dead counter = DEAD_TIME.
- End evaluation:
  - len > MAX_PULSE_LEN: reject_count++, no bin.
  - Otherwise: result = peak >> (SAMPLE_WIDTH-BIN_BITS); pulse_count++.
- DEAD: decrement on each sample_valid beat. When it reaches 0, go to ARMED if amp < threshold on that beat, else WAIT_LOW. If DEAD_TIME=0, go straight to ARMED/WAIT_LOW by the same rule.
- enable=0 in any state: go to IDLE next cycle; an in-progress pulse is discarded with no counter change. A pending bin_valid still completes its handshake.
- Output register, one entry:
  - A result is registered the cycle after the ending sample's beat (latency 1 clk).
  - bin_valid stays high and bin_index stays stable until bin_valid & bin_ready.
  - New result while the register is occupied and not being handshaked that cycle: the new result is dropped, drop_count++, and pulse_count is still incremented.
  - New result in the same cycle as a handshake: the register is reloaded and bin_valid stays 1.
- Counters saturate at all-ones; there is no wrap.
- threshold=0: any beat arms and triggers. lo saturates at 0, so a pulse ends only by disable; len saturates and the pulse is rejected if it is ever ended.
- reset_n assertion mid-operation clears everything immediately (asynchronous); deassertion is synchronised externally.

Test Plan:
- Single pulse:
  - Setup: baseline=100, threshold=200, hysteresis=20, enable=1, bin_ready=1.
  - Stimulus: samples 100,250,600,900,500,150.
  - Required: trigger on 600; peak=800; pulse ends on 150 (amp 50 < 180); len=3. One bin_valid cycle with bin_index=50, one cycle after the 150 beat; pulse_count=1.
- Pile-up:
  - Stimulus: same settings, 70 consecutive beats of 900 then 100.
  - Required: no bin_valid; reject_count=1; pulse_count=0.
- Backpressure:
  - Stimulus: bin_ready=0; two valid pulses (peaks 800, 1600) separated by more than DEAD_TIME.
  - Required: bin_index=50 held stable; second pulse dropped; drop_count=1, pulse_count=2. Raising bin_ready gives a single handshake.
- Dead time and arming:
  - Stimulus: a second pulse starting 5 beats after the first one ends (DEAD_TIME=8).
  - Required: second pulse ignored and no arming until amp < threshold after DEAD expires.
- Enable mid-pulse and late enable:
  - Drop enable during IN_PULSE: no output, counters unchanged, state IDLE.
  - Raise enable while amp=900: no trigger until amp falls below 200 and rises again.
- Reset mid-pulse with bin_valid pending:
  - Stimulus: assert reset_n=0 asynchronously.
  - Required: bin_valid=0, all counters 0, state IDLE within the same cycle.
